// File: rtl/usb_tx_serializer.sv
// USB full-speed TX serializer: SYNC, bit-stuffed NRZI data, optional CRC16, EOP.
// Define USB_TX_CRC16_EN to append the inverted CRC16 of all data bits before EOP.
module usb_tx_serializer #(
  parameter int WORD_W       = 16,
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LIMIT  = 6,
  parameter int MAX_WORDS    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              transmit_empty,
  input  logic              transmit_start,
  output logic              read_enable,
  output logic              d_plus_out,
  output logic              d_minus_out,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_error
);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
  localparam int WCNT_W = $clog2(MAX_WORDS + 1);
  localparam int IDX_W  = $clog2(WORD_W + 16);

`ifdef USB_TX_CRC16_EN
  typedef enum logic [2:0] {IDLE, SYNC, DATA, CRC, EOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP} state_t;
`endif

  state_t            state;
  logic [CNT_W-1:0]  clk_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [ONES_W-1:0] ones;
  logic [WCNT_W-1:0] words;
  logic [WORD_W-1:0] shift;
  logic              nrzi;
`ifdef USB_TX_CRC16_EN
  logic [15:0]       crc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return (c >> 1) ^ ((c[0] ^ b) ? 16'hA001 : 16'h0000);
  endfunction
`endif

  logic bit_end, stuff_due, fetch, send, bval, nrzi_next;

  // FIFO handshake: read_enable is high for the last clk of a fetch-point bit time,
  // only while transmit_empty=0; tx_data is consumed on the edge that ends that clk.
  assign bit_end     = clk_cnt == CNT_W'(CLKS_PER_BIT - 1);
  assign stuff_due   = ones == ONES_W'(STUFF_LIMIT);
  assign fetch       = bit_end && ((state == SYNC && bit_idx == IDX_W'(7)) ||
                       (state == DATA && bit_idx == IDX_W'(WORD_W - 1) && !stuff_due));
  assign read_enable = fetch && !transmit_empty && (words < WCNT_W'(MAX_WORDS));
  assign nrzi_next   = bval ? nrzi : ~nrzi;

  // Selects the next raw bit (before NRZI) to place on the line at this bit boundary.
  always_comb begin
    send = 1'b0;
    bval = 1'b0;
    if (bit_end) begin
      case (state)
        SYNC: begin
          if (bit_idx != IDX_W'(7)) begin
            send = 1'b1;
            bval = (bit_idx == IDX_W'(6));
          end else if (read_enable) begin
            send = 1'b1;
            bval = tx_data[0];
          end
        end
        DATA: begin
          if (stuff_due) send = 1'b1;
          else if (!fetch) begin
            send = 1'b1;
            bval = shift[0];
          end else if (read_enable) begin
            send = 1'b1;
            bval = tx_data[0];
          end
`ifdef USB_TX_CRC16_EN
          else if (transmit_empty) begin
            send = 1'b1;
            bval = ~crc[0];
          end
`endif
        end
`ifdef USB_TX_CRC16_EN
        CRC: begin
          if (stuff_due) send = 1'b1;
          else if (bit_idx != IDX_W'(15)) begin
            send = 1'b1;
            bval = ~crc[0];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      ones        <= '0;
      words       <= '0;
      shift       <= '0;
      nrzi        <= 1'b1;
      d_plus_out  <= 1'b1;
      d_minus_out <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc         <= 16'hFFFF;
`endif
    end else begin
      tx_done <= 1'b0;
      clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
      if (send) begin
        nrzi        <= nrzi_next;
        d_plus_out  <= nrzi_next;
        d_minus_out <= ~nrzi_next;
        ones        <= bval ? ones + 1'b1 : '0;
      end
      case (state)
        IDLE: if (transmit_start) begin
          // First SYNC bit is a 0, so the line toggles J->K on this edge.
          state       <= SYNC;
          tx_busy     <= 1'b1;
          tx_error    <= 1'b0;
          clk_cnt     <= '0;
          bit_idx     <= '0;
          ones        <= '0;
          words       <= '0;
          nrzi        <= 1'b0;
          d_plus_out  <= 1'b0;
          d_minus_out <= 1'b1;
`ifdef USB_TX_CRC16_EN
          crc         <= 16'hFFFF;
`endif
        end
        SYNC, DATA: if (bit_end && !(state == DATA && stuff_due)) begin
          if (!fetch) begin
            bit_idx <= bit_idx + 1'b1;
            if (state == DATA) begin
              shift <= shift >> 1;
`ifdef USB_TX_CRC16_EN
              crc   <= crc_step(crc, bval);
`endif
            end
          end else if (read_enable) begin
            state   <= DATA;
            bit_idx <= '0;
            shift   <= tx_data >> 1;
            words   <= words + 1'b1;
`ifdef USB_TX_CRC16_EN
            crc     <= crc_step(crc, tx_data[0]);
`endif
          end else begin
            state       <= EOP;
            bit_idx     <= '0;
            d_plus_out  <= 1'b0;
            d_minus_out <= 1'b0;
            if (!transmit_empty) tx_error <= 1'b1;
`ifdef USB_TX_CRC16_EN
            else if (state == DATA) begin
              state       <= CRC;
              d_plus_out  <= nrzi_next;
              d_minus_out <= ~nrzi_next;
              crc         <= crc >> 1;
            end
`endif
          end
        end
`ifdef USB_TX_CRC16_EN
        CRC: if (bit_end && !stuff_due) begin
          if (bit_idx != IDX_W'(15)) begin
            bit_idx <= bit_idx + 1'b1;
            crc     <= crc >> 1;
          end else begin
            state       <= EOP;
            bit_idx     <= '0;
            d_plus_out  <= 1'b0;
            d_minus_out <= 1'b0;
          end
        end
`endif
        EOP: if (bit_end) begin
          if (bit_idx == IDX_W'(2)) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            nrzi    <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_W'(1)) begin
              d_plus_out  <= 1'b1;
              d_minus_out <= 1'b0;
              nrzi        <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer (default build): FIFO model, line decoder, word scoreboard.
module tb_usb_tx_serializer;
  localparam int W    = 16;
  localparam int CPB  = 8;
  localparam int MAXW = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] tx_data = '0;
  logic         transmit_empty = 1'b1;
  logic         transmit_start = 1'b0;
  logic         read_enable, d_plus_out, d_minus_out, tx_busy, tx_done, tx_error;

  always #5 clk = ~clk;

  usb_tx_serializer #(.WORD_W(W), .CLKS_PER_BIT(CPB), .STUFF_LIMIT(6), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .transmit_empty(transmit_empty),
    .transmit_start(transmit_start), .read_enable(read_enable), .d_plus_out(d_plus_out),
    .d_minus_out(d_minus_out), .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int n_vec = 0, n_fail = 0, total_reads = 0, re_empty_err = 0;
  bit pop_pending = 1'b0;

  // FWFT FIFO model: pops after the edge on which read_enable was seen high.
  always @(negedge clk) begin
    bit old;
    old = pop_pending;
    pop_pending = read_enable;
    if (read_enable) begin
      total_reads++;
      if (transmit_empty) re_empty_err++;
    end
    if (old && fifo_q.size() > 0) void'(fifo_q.pop_front());
    transmit_empty = (fifo_q.size() == 0);
    tx_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [4:0][W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(w[i]);
      if (i < MAXW) exp_q.push_back(w[i]);
    end
  endtask

  function automatic int model_bits(input logic [4:0][W-1:0] w, input int n);
    int ones, st, nw;
    ones = 1;
    st = 0;
    nw = (n < MAXW) ? n : MAXW;
    for (int i = 0; i < nw; i++)
      for (int j = 0; j < W; j++) begin
        ones = w[i][j] ? ones + 1 : 0;
        if (ones == 6) begin st++; ones = 0; end
      end
    return 8 + W * nw + st + 3;
  endfunction

  task automatic run_packet(input string name, input int exp_bits, input int exp_reads,
                            input bit exp_err, input bit poke);
    int r0, e0, nb, ones, accn, stuff_bad;
    logic prev, b;
    logic [7:0] syncv;
    logic [W-1:0] acc;
    bit seen_se0;
    r0 = total_reads;
    e0 = re_empty_err;
    repeat (2) @(negedge clk);
    transmit_start = 1'b1;
    @(posedge clk);
    #1 transmit_start = 1'b0;
    check($sformatf("%s first K", name), {d_plus_out, d_minus_out}, 2'b01);
    check($sformatf("%s busy/err at start", name), {tx_busy, tx_error}, 2'b10);
    repeat (5) @(negedge clk);
    prev = 1'b1; ones = 0; nb = 0; accn = 0; stuff_bad = 0; seen_se0 = 1'b0;
    syncv = '0; acc = '0;
    while (nb < 400 && !seen_se0) begin
      nb++;
      if (!d_plus_out && !d_minus_out) seen_se0 = 1'b1;
      else begin
        b = (d_plus_out == prev);
        prev = d_plus_out;
        if (nb <= 8) begin
          syncv[nb-1] = b;
          ones = b ? ones + 1 : 0;
        end else if (ones == 6) begin
          if (b) stuff_bad++;
          ones = 0;
        end else begin
          ones = b ? ones + 1 : 0;
          acc[accn] = b;
          accn++;
          if (accn == W) begin
            accn = 0;
            if (exp_q.size() == 0) begin
              n_vec++;
              n_fail++;
              $display("FAIL %s extra word: got 0x%0h, expected none", name, acc);
            end else check($sformatf("%s data word", name), acc, exp_q.pop_front());
          end
        end
        if (poke && nb == 12) transmit_start = 1'b1;
        @(negedge clk);
        transmit_start = 1'b0;
        repeat (CPB - 1) @(negedge clk);
      end
    end
    check($sformatf("%s SE0 reached", name), seen_se0, 1);
    check($sformatf("%s sync pattern", name), syncv, 8'h80);
    check($sformatf("%s stuffed bit value", name), stuff_bad, 0);
    check($sformatf("%s partial word bits", name), accn, 0);
    check($sformatf("%s words not sent", name), exp_q.size(), 0);
    repeat (CPB) @(negedge clk);
    check($sformatf("%s EOP second SE0", name), {d_plus_out, d_minus_out}, 2'b00);
    repeat (CPB) @(negedge clk);
    check($sformatf("%s EOP J", name), {d_plus_out, d_minus_out, tx_done}, 3'b100);
    repeat (4) @(negedge clk);
    check($sformatf("%s done/busy/err", name), {tx_done, tx_busy, tx_error}, {2'b10, exp_err});
    check($sformatf("%s bit times", name), nb + 2, exp_bits);
    @(negedge clk);
    check($sformatf("%s done pulse width", name), tx_done, 0);
    check($sformatf("%s read count", name), total_reads - r0, exp_reads);
    check($sformatf("%s read while empty", name), re_empty_err - e0, 0);
    fifo_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    int n;
    logic [4:0][W-1:0] w;
    int bits;
    int reads;
    bit err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [4:0][W-1:0] w;
    int n, r0;
    tbl[0] = '{1, {16'h0, 16'h0, 16'h0, 16'h0, 16'h00A5}, 27, 1, 1'b0};
    tbl[1] = '{1, {16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF}, 29, 1, 1'b0};
    tbl[2] = '{0, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0000}, 11, 0, 1'b0};
    tbl[3] = '{5, {16'h0F0F, 16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, 75, 4, 1'b1};
    tbl[4] = '{1, {16'h0, 16'h0, 16'h0, 16'h0, 16'hFC00}, 28, 1, 1'b0};
    tbl[5] = '{4, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0000}, 75, 4, 1'b0};
    tbl[6] = '{2, {16'h0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF}, 48, 2, 1'b0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {d_plus_out, d_minus_out, read_enable, tx_busy, tx_error, tx_done},
          6'b100000);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      load(tbl[i].w, tbl[i].n);
      run_packet($sformatf("vec%0d", i), tbl[i].bits, tbl[i].reads, tbl[i].err, 1'b0);
      if (tbl[i].err) begin
        repeat (20) @(negedge clk);
        check($sformatf("vec%0d error sticky", i), {tx_error, tx_busy}, 2'b10);
      end
    end

    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 3);
      w = '0;
      for (int i = 0; i < n; i++)
        w[i] = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 65535))
                                           : (16'hFFFF ^ (16'h1 << $urandom_range(0, 15)));
      load(w, n);
      run_packet($sformatf("rand%0d", k), model_bits(w, n), n, 1'b0, 1'b0);
    end

    w = '0;
    w[0] = 16'h1234;
    w[1] = 16'hABCD;
    load(w, 2);
    run_packet("start while busy", model_bits(w, 2), 2, 1'b0, 1'b1);

    fifo_q.push_back(16'h5A5A);
    fifo_q.push_back(16'hC3C3);
    r0 = total_reads;
    repeat (2) @(negedge clk);
    transmit_start = 1'b1;
    @(negedge clk);
    transmit_start = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-data reset line/busy", {d_plus_out, d_minus_out, tx_busy, tx_done}, 4'b1000);
    repeat (5 * CPB) @(negedge clk);
    check("after reset idle", {d_plus_out, d_minus_out, tx_busy, read_enable}, 4'b1000);
    check("after reset reads", total_reads - r0, 1);
    fifo_q.delete();
    exp_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
